keypad_scan: RTL

//   Input side of the calculator: scans a 4x4 matrix keypad, debounces it, and emits
//   one key code per physical press. The arithmetic/control logic consumes it, and

---
 rtl/keypad_scan_if.sv | 25 ++
 rtl/keypad_scan.sv | 131 +++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// Keypad matrix bundle: column drive out, row sense in,
// plus the accepted-key report toward the calculator core.
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column strobe, 2-FF row sync, press/release
// debounce, one key_valid pulse per accepted press.
module keypad_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input logic           clk,
    input logic           rst,
    keypad_scan_if.master bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [1:0]    state;
    logic [3:0]    row_meta;
    logic [3:0]    rs;
    logic [3:0]    row_pat;
    logic [SW-1:0] slot_cnt;
    logic [DW-1:0] deb_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    prio_row;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          tick;
    logic          pressed;
    logic          deb_done;
    logic          row_up;

    assign tick     = (slot_cnt == SLOT_LAST);
    assign pressed  = (rs != 4'b1111);
    assign deb_done = (deb_cnt == DEB_LAST);
    // Release is judged on the reported row only, so a
    // second key in the same column cannot hold it off.
    assign row_up   = rs[key_code[3:2]];

    always_comb begin
        priority case (1'b1)
            !rs[0]:  prio_row = 2'd0;
            !rs[1]:  prio_row = 2'd1;
            !rs[2]:  prio_row = 2'd2;
            default: prio_row = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'b1111;
            rs       <= 4'b1111;
        end else begin
            row_meta <= bus.row;
            rs       <= row_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
        end else if (tick) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            deb_cnt   <= '0;
            row_pat   <= 4'b1111;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (pressed) begin
                            key_code <= {prio_row, col_idx};
                            row_pat  <= rs;
                            deb_cnt  <= '0;
                            state    <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                    DEBOUNCE: begin
                        if (rs != row_pat) begin
                            state   <= SCAN;
                            col_idx <= col_idx + 1'b1;
                        end else if (deb_done) begin
                            state     <= HELD;
                            key_valid <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (row_up) begin
                            state   <= RELEASE;
                            deb_cnt <= '0;
                        end
                    end
                    RELEASE: begin
                        if (pressed) begin
                            deb_cnt <= '0;
                        end else if (deb_done) begin
                            state   <= SCAN;
                            col_idx <= col_idx + 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign bus.col       = ~(4'b0001 << col_idx);
    assign bus.key_code  = key_code;
    assign bus.key_valid = key_valid;
    assign bus.key_held  = (state == HELD);
endmodule
